// File: rtl/viterbi_seq_ctrl_if.sv
// Viterbi sequencer control bundle: symbol handshake plus datapath strobes.
// slave = sequencer view, master = symbol source / datapath view.
interface viterbi_seq_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic              acs_en;
    logic              acs_init;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              tb_start;
    logic              tb_en;
    logic              dec_valid;
    logic              busy;
    logic              frame_done;

    modport slave (
        input  in_valid,
        output in_ready, acs_en, acs_init,
        output mem_wr_en, mem_wr_addr,
        output mem_rd_en, mem_rd_addr,
        output tb_start, tb_en, dec_valid,
        output busy, frame_done
    );

    modport master (
        output in_valid,
        input  in_ready, acs_en, acs_init,
        input  mem_wr_en, mem_wr_addr,
        input  mem_rd_en, mem_rd_addr,
        input  tb_start, tb_en, dec_valid,
        input  busy, frame_done
    );
endinterface

// File: rtl/viterbi_seq_ctrl.sv
// Viterbi decoder control sequencer: fills survivor memory one symbol per
// accept, runs a reverse traceback sweep, then pulses frame_done.
// Ports: clk, rst (sync, active-high), bus (viterbi_seq_ctrl_if.slave).
module viterbi_seq_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    viterbi_seq_ctrl_if.slave    bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_TB,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [ADDR_W-1:0] tb_addr_q, tb_addr_d;
    logic              rd_dly_q;

    logic accept;
    logic rd_en;

    // rst gates ready so a same-cycle in_valid never strobes the ACS
    assign bus.in_ready = ~rst &
        ((state_q == S_IDLE) || (state_q == S_FILL));
    assign accept = bus.in_valid & bus.in_ready;

    assign bus.acs_en      = accept;
    assign bus.mem_wr_en   = accept;
    assign bus.mem_wr_addr = sym_cnt_q;
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = tb_addr_q;
    assign bus.tb_en       = rd_dly_q;
    assign bus.dec_valid   = rd_dly_q;
    assign bus.busy        = (state_q != S_IDLE);

    always_comb begin
        state_d        = state_q;
        sym_cnt_d      = sym_cnt_q;
        tb_addr_d      = tb_addr_q;
        rd_en          = 1'b0;
        bus.acs_init   = 1'b0;
        bus.tb_start   = 1'b0;
        bus.frame_done = 1'b0;
        unique case (state_q)
            S_IDLE, S_FILL: begin
                bus.acs_init = accept && (state_q == S_IDLE);
                if (accept) begin
                    if (sym_cnt_q == LAST) begin
                        state_d   = S_TB;
                        tb_addr_d = LAST;
                        sym_cnt_d = '0;
                    end else begin
                        state_d   = S_FILL;
                        sym_cnt_d = sym_cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_TB: begin
                rd_en = 1'b1;
                // sweep always starts at LAST, so that marks the first cycle
                bus.tb_start = (tb_addr_q == LAST);
                if (tb_addr_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    tb_addr_d = tb_addr_q - ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                bus.frame_done = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sym_cnt_q <= '0;
            tb_addr_q <= '0;
            rd_dly_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            tb_addr_q <= tb_addr_d;
            rd_dly_q  <= rd_en;
        end
    end
endmodule

// File: doc/viterbi_seq_ctrl.md
Name: viterbi_seq_ctrl

Overview:
Control sequencer for the Viterbi decoder datapath (branch-metric units, ACS array, survivor memory, traceback unit). Accepts received symbol pairs over a valid/ready handshake and strobes the BMC/ACS stage once per accepted pair. Writes one survivor-memory entry per symbol. At end of frame it runs a traceback read sweep, then pulses frame completion. Drives control only; carries no metric or survivor data.

Parameters:
FRAME_LEN, 8, symbols per frame (>=2)
ADDR_W, 3, survivor memory address width; 2**ADDR_W >= FRAME_LEN

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  received pair valid
in_ready  output  1  sequencer can accept a pair this cycle
acs_en  output  1  BMC/ACS update strobe, one per accepted pair
acs_init  output  1  with acs_en: first symbol of frame, ACS loads initial metrics
mem_wr_en  output  1  survivor memory write enable
mem_wr_addr  output  ADDR_W  survivor write address
mem_rd_en  output  1  survivor memory read enable (1-cycle read latency)
mem_rd_addr  output  ADDR_W  survivor read address
tb_start  output  1  first traceback cycle; traceback unit loads start state
tb_en  output  1  traceback unit consumes read data this cycle
dec_valid  output  1  traceback unit's decoded bit is valid (reverse order)
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- One clock, clk. rst is synchronous and active-high. Reset forces state IDLE, sym_cnt=0 and tb_addr=0. All registered outputs reset to 0. in_ready=1 in the first cycle after reset.
- States: IDLE, FILL, TB, DRAIN, DONE.
- Accept = in_valid & in_ready. acs_en = mem_wr_en = accept, combinationally in the same cycle. mem_wr_addr = sym_cnt.
- IDLE: in_ready=1. On accept: acs_init=1, sym_cnt<=1, go to FILL. If FRAME_LEN symbols are reached on this accept, go to TB instead (not reachable for FRAME_LEN>=2).
- FILL: in_ready=1. acs_init=0. On accept, sym_cnt increments. An in_valid gap holds state and asserts no strobes.
- Accepting symbol index FRAME_LEN-1 in FILL goes to TB next cycle, with tb_addr<=FRAME_LEN-1 and sym_cnt<=0.
- TB: in_ready=0. mem_rd_en=1 every cycle. mem_rd_addr=tb_addr, which decrements by 1 per cycle. tb_start=1 only in the first TB cycle.
  - tb_en and dec_valid are mem_rd_en delayed 1 cycle (registered).
  - After the cycle reading address 0, go to DRAIN.
  - TB lasts exactly FRAME_LEN cycles. No backpressure.
- DRAIN: in_ready=0. mem_rd_en=0. Registered tb_en/dec_valid cover the final read. Go to DONE.
- DONE: frame_done=1 for exactly one cycle. in_ready=0. Go to IDLE.
- Total decoded bits per frame = FRAME_LEN dec_valid pulses, consecutive cycles, first one cycle after tb_start.
- busy=0 only in IDLE. acs_en, acs_init, mem_wr_en are never asserted outside IDLE/FILL. mem_rd_en is never asserted outside TB.
- Address arithmetic is unsigned ADDR_W bits. tb_addr never wraps below 0, because the state changes at 0.
- in_valid held high through TB/DRAIN/DONE is ignored (in_ready=0). The next frame's first accept can occur the cycle after DONE, with acs_init=1.
- rst mid-frame, in any state: next cycle is IDLE with all strobes 0. A partial frame is discarded and no frame_done is produced.
- rst and in_valid in the same cycle: rst wins, no acs_en.

Test Plan:
- FRAME_LEN=8, in_valid held high 8 cycles after reset → acs_en 8 consecutive cycles; acs_init only on cycle 0; mem_wr_addr 0..7; then TB with mem_rd_addr 7,6,...,0.
- Same frame → tb_start coincides with rd_addr 7. dec_valid 8 consecutive cycles starting 1 cycle later. frame_done pulses 1 cycle after the last dec_valid. busy falls the following cycle.
- in_valid toggled 1,0,1,0,... → acs_en only on high cycles; mem_wr_addr still 0..7 contiguous; TB begins after the 8th accept.
- in_valid held high through the full frame and the next → no acs_en during TB/DRAIN/DONE; next frame's first accept has acs_init=1 and mem_wr_addr=0.
- rst asserted at 5th symbol, and separately at 3rd TB cycle → next cycle IDLE, all strobes 0, no frame_done; a subsequent full frame decodes normally.
- rst held with in_valid=1 → in_ready=0 during rst, no acs_en; in_ready=1 the cycle after rst deasserts.
